// File: rtl/hack_pkg.sv
// ============================================================================
// Module      : hack_pkg
// Description : Shared encodings and default widths for Hack peripherals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hack_pkg;

    localparam int C_DEF_WIDTH   = 16;
    localparam int C_DEF_PRESC_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage : hack_pkg

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider; tick is high every prescale+1 enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import hack_pkg::*;
#(
    parameter int PRESC_W = C_DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);

    logic [PRESC_W-1:0] r_presc_cnt;
    logic               w_wrap;

    assign w_wrap = (r_presc_cnt == prescale);
    assign tick   = enable && !clear && w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
        end else if (clear) begin
            r_presc_cnt <= '0;
        end else if (enable) begin
            if (w_wrap) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
            end
        end
    end

endmodule : tick_prescaler

`default_nettype wire

// File: rtl/countdown_timer16.sv
// ============================================================================
// Module      : countdown_timer16
// Description : Loadable down-counter with prescaler, one-shot/auto-reload,
//               expiry strobe and sticky interrupt flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer16
    import hack_pkg::*;
#(
    parameter int WIDTH   = C_DEF_WIDTH,
    parameter int PRESC_W = C_DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               start,
    input  logic               stop,
    input  logic               auto_reload,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               irq_clr,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               expired,
    output logic               irq
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic [WIDTH-1:0] w_start_val;
    logic             r_busy;
    logic             r_expired;
    logic             w_expired_nxt;
    logic             r_irq;
    logic             w_irq_nxt;
    logic             w_tick;
    logic             w_presc_en;
    logic             w_presc_clear;

    // The divider is held at zero outside RUN so every start begins a full period.
    assign w_presc_en    = (r_state == ST_RUN);
    assign w_presc_clear = (r_state != ST_RUN) || stop;

    tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_presc_clear),
        .enable   (w_presc_en),
        .prescale (prescale),
        .tick     (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_reload  <= w_reload_nxt;
            r_busy    <= (w_state_nxt == ST_RUN);
            r_expired <= w_expired_nxt;
            r_irq     <= w_irq_nxt;
        end
    end

    // Start in IDLE is judged against the value being loaded in the same cycle.
    assign w_start_val = load ? load_val : r_count;

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_reload_nxt  = r_reload;
        w_expired_nxt = 1'b0;
        w_irq_nxt     = irq_clr ? 1'b0 : r_irq;

        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_reload_nxt = load_val;
                    w_count_nxt  = load_val;
                end
                if (start && !stop) begin
                    if (w_start_val != '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_expired_nxt = 1'b1;
                        w_irq_nxt     = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (load) begin
                    w_reload_nxt = load_val;
                end
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count == '0) begin
                    // Unreachable in normal use; never decrement past zero.
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (r_count == WIDTH'(1)) begin
                        w_expired_nxt = 1'b1;
                        w_irq_nxt     = 1'b1;
                        if (auto_reload && (r_reload != '0)) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign count   = r_count;
    assign busy    = r_busy;
    assign expired = r_expired;
    assign irq     = r_irq;

endmodule : countdown_timer16

`default_nettype wire
